// File: rtl/wb_write_queue.sv
// wb_write_queue: ALU/load writeback FIFO draining one entry per cycle into the register-file
// write port, with pending-register lookup for two issue sources. Define WBQ_FWD_EN for forwarding data.

module wbq_pend_lane #(
  parameter int DEPTH = 4
) (
  input  logic [2:0]             query,
  input  logic [DEPTH-1:0]       slot_vld,
  input  logic [DEPTH-1:0][2:0]  slot_addr,
  input  logic                   out_we,
  input  logic [2:0]             out_addr,
  output logic                   pend
);
  always_comb begin
    pend = out_we && (out_addr == query);
    for (int k = 0; k < DEPTH; k++)
      if (slot_vld[k] && (slot_addr[k] == query)) pend = 1'b1;
    if (query == 3'd7) pend = 1'b0;
  end
endmodule

`ifdef WBQ_FWD_EN
module wbq_fwd_lane #(
  parameter int DEPTH = 4
) (
  input  logic [2:0]             query,
  input  logic [DEPTH-1:0]       slot_vld,
  input  logic [DEPTH-1:0][2:0]  slot_addr,
  input  logic [DEPTH-1:0][31:0] slot_value,
  input  logic                   out_we,
  input  logic [2:0]             out_addr,
  input  logic [31:0]            out_value,
  output logic [31:0]            value
);
  // Slots are ordered oldest-first, so the last match seen is the youngest write.
  always_comb begin
    value = '0;
    if (out_we && (out_addr == query)) value = out_value;
    for (int k = 0; k < DEPTH; k++)
      if (slot_vld[k] && (slot_addr[k] == query)) value = slot_value[k];
    if (query == 3'd7) value = '0;
  end
endmodule
`endif

module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [2:0]                 alu_addr,
  input  logic [31:0]                alu_value,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [2:0]                 ld_addr,
  input  logic [31:0]                ld_value,
  output logic [2:0]                 write_addr,
  output logic [31:0]                write_value,
  output logic                       write_enable,
  input  logic [2:0]                 query_addr1,
  input  logic [2:0]                 query_addr2,
  output logic                       pend1,
  output logic                       pend2,
  output logic                       fwd_valid1,
  output logic                       fwd_valid2,
  output logic [31:0]                fwd_value1,
  output logic [31:0]                fwd_value2,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NUM_LANES = 2;

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] value;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head, tail;
  logic            full, acc_alu, acc_ld, enq, pop;
  entry_t          in_ent;

  // Ready depends only on occupancy, reset and alu_valid; a pop on the same edge does not free a slot.
  assign full      = (count == CW'(DEPTH));
  assign alu_ready = rst_n && !full;
  assign ld_ready  = rst_n && !full && !alu_valid;
  assign acc_alu   = alu_valid && alu_ready;
  assign acc_ld    = ld_valid && ld_ready;

  always_comb begin
    in_ent = acc_alu ? entry_t'{alu_addr, alu_value} : entry_t'{ld_addr, ld_value};
  end

  // R7 writes complete the handshake but never enter the queue.
  assign enq = (acc_alu || acc_ld) && (in_ent.addr != 3'd7);
  assign pop = (count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_value  <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (pop) begin
        head        <= head + PW'(1);
        write_addr  <= mem[head].addr;
        write_value <= mem[head].value;
      end
      write_enable <= pop;
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[tail] <= in_ent;
  end

  // Oldest-first view of the occupied slots for the lookup lanes.
  logic [DEPTH-1:0]           ord_vld;
  logic [DEPTH-1:0][2:0]      ord_addr;
  logic [NUM_LANES-1:0][2:0]  query;
  logic [NUM_LANES-1:0]       pend_v;

  assign query = {query_addr2, query_addr1};

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic [PW-1:0] idx;
    assign idx         = head + PW'(k);
    assign ord_vld[k]  = (CW'(k) < count);
    assign ord_addr[k] = mem[idx].addr;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_pend
    wbq_pend_lane #(.DEPTH(DEPTH)) u_pend (
      .query     (query[l]),
      .slot_vld  (ord_vld),
      .slot_addr (ord_addr),
      .out_we    (write_enable),
      .out_addr  (write_addr),
      .pend      (pend_v[l])
    );
  end

  assign pend1 = pend_v[0];
  assign pend2 = pend_v[1];

`ifdef WBQ_FWD_EN
  logic [DEPTH-1:0][31:0]      ord_value;
  logic [NUM_LANES-1:0][31:0]  fwd_v;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot_val
    assign ord_value[k] = mem[g_slot[k].idx].value;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_fwd
    wbq_fwd_lane #(.DEPTH(DEPTH)) u_fwd (
      .query      (query[l]),
      .slot_vld   (ord_vld),
      .slot_addr  (ord_addr),
      .slot_value (ord_value),
      .out_we     (write_enable),
      .out_addr   (write_addr),
      .out_value  (write_value),
      .value      (fwd_v[l])
    );
  end

  assign fwd_valid1 = pend1;
  assign fwd_valid2 = pend2;
  assign fwd_value1 = fwd_v[0];
  assign fwd_value2 = fwd_v[1];
`else
  assign fwd_valid1 = 1'b0;
  assign fwd_valid2 = 1'b0;
  assign fwd_value1 = '0;
  assign fwd_value2 = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: accepted writes are queued at the edge,
// a negedge monitor pops them against the write port and checks occupancy/ready.
module tb_wb_write_queue;
  localparam int DEPTH = 4;

  logic        clk, rst_n;
  logic        alu_valid, alu_ready, ld_valid, ld_ready;
  logic [2:0]  alu_addr, ld_addr, write_addr, query_addr1, query_addr2;
  logic [31:0] alu_value, ld_value, write_value, fwd_value1, fwd_value2;
  logic        write_enable, pend1, pend2, fwd_valid1, fwd_valid2;
  logic [$clog2(DEPTH):0] count;

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_value(alu_value),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_value(ld_value),
    .write_addr(write_addr), .write_value(write_value), .write_enable(write_enable),
    .query_addr1(query_addr1), .query_addr2(query_addr2),
    .pend1(pend1), .pend2(pend2),
    .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
    .fwd_value1(fwd_value1), .fwd_value2(fwd_value2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [34:0] sb[$];
  int   mcnt = 0;
  logic exp_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Acceptance model: ALU first, ready only when not full and out of reset; one drain per edge.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        sb.delete();
        mcnt   = 0;
        exp_we = 1'b0;
      end else begin
        automatic bit nfull = (mcnt != DEPTH);
        automatic int enq = 0;
        automatic int pop = (mcnt != 0) ? 1 : 0;
        exp_we = (pop == 1);
        if (alu_valid && nfull) begin
          if (alu_addr != 3'd7) begin sb.push_back({alu_addr, alu_value}); enq = 1; end
        end else if (ld_valid && nfull) begin
          if (ld_addr != 3'd7) begin sb.push_back({ld_addr, ld_value}); enq = 1; end
        end
        mcnt = mcnt + enq - pop;
      end
    end
  end

  // Monitor: compares each write pulse against the scoreboard head, plus per-cycle status.
  initial begin
    forever begin
      @(negedge clk);
      chk("count", 32'(count), 32'(mcnt));
      chk("write_enable", 32'(write_enable), 32'(exp_we));
      chk("alu_ready", 32'(alu_ready), 32'(rst_n && (mcnt != DEPTH)));
      chk("ld_ready", 32'(ld_ready), 32'(rst_n && (mcnt != DEPTH) && !alu_valid));
`ifndef WBQ_FWD_EN
      chk("fwd_valid1", 32'(fwd_valid1), 32'd0);
      chk("fwd_value2", fwd_value2, 32'd0);
`endif
      if (write_enable) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got R%0d=%0h expected no write at %0t",
                   write_addr, write_value, $time);
        end else begin
          automatic logic [34:0] e = sb.pop_front();
          chk("write_addr", 32'(write_addr), 32'(e[34:32]));
          chk("write_value", write_value, e[31:0]);
        end
      end
    end
  end

  task automatic drive(input logic av, input logic [2:0] aa, input logic [31:0] avl,
                       input logic lv, input logic [2:0] la, input logic [31:0] lvl);
    alu_valid = av; alu_addr = aa; alu_value = avl;
    ld_valid  = lv; ld_addr  = la; ld_value  = lvl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    query_addr1 = 3'd3;
    query_addr2 = 3'd4;
    // Reset held for two edges while the ALU offers a result
    drive(1'b1, 3'd3, 32'h1111, 1'b0, 3'd0, 32'd0);
    drive(1'b1, 3'd3, 32'h1111, 1'b0, 3'd0, 32'd0);
    chk("reset_alu_ready", 32'(alu_ready), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    idle();
    chk("post_reset_alu_ready", 32'(alu_ready), 32'd1);

    // Single write and its pending window
    drive(1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0);
    chk("single_pend1_queued", 32'(pend1), 32'd1);
    chk("single_pend2_other", 32'(pend2), 32'd0);
    idle();
    chk("single_pend1_inflight", 32'(pend1), 32'd1);
    chk("single_we", 32'(write_enable), 32'd1);
    idle();
    chk("single_pend1_done", 32'(pend1), 32'd0);

    // Both producers valid: load waits until the ALU stream ends
    for (int i = 0; i < 6; i++)
      drive(1'b1, 3'(i), 32'hA0 + 32'(i), 1'b1, 3'd1, 32'hBAD);
    drive(1'b0, 3'd0, 32'd0, 1'b1, 3'd1, 32'h1D);
    idle();
    idle();

    // Zero register is swallowed
    query_addr1 = 3'd7;
    query_addr2 = 3'd7;
    drive(1'b1, 3'd7, 32'h1234, 1'b0, 3'd0, 32'd0);
    chk("r7_pend1", 32'(pend1), 32'd0);
    chk("r7_pend2", 32'(pend2), 32'd0);
    chk("r7_count", 32'(count), 32'd0);
    idle();
    chk("r7_no_we", 32'(write_enable), 32'd0);
    idle();

    // Same-register ordering
    query_addr1 = 3'd2;
    query_addr2 = 3'd6;
    drive(1'b1, 3'd2, 32'd5, 1'b0, 3'd0, 32'd0);
    chk("same_pend1_first", 32'(pend1), 32'd1);
    drive(1'b1, 3'd2, 32'd9, 1'b0, 3'd0, 32'd0);
    chk("same_pend1_both", 32'(pend1), 32'd1);
`ifdef WBQ_FWD_EN
    chk("same_fwd_valid1", 32'(fwd_valid1), 32'd1);
    chk("same_fwd_value1", fwd_value1, 32'd9);
`else
    chk("same_fwd_valid1_off", 32'(fwd_valid1), 32'd0);
`endif
    idle();
    chk("same_pend1_last", 32'(pend1), 32'd1);
    idle();
    chk("same_pend1_clear", 32'(pend1), 32'd0);

    // Reset in the middle of a stream
    query_addr1 = 3'd2;
    query_addr2 = 3'd1;
    drive(1'b1, 3'd1, 32'h71, 1'b0, 3'd0, 32'd0);
    drive(1'b1, 3'd2, 32'h72, 1'b0, 3'd0, 32'd0);
    rst_n = 1'b0;
    drive(1'b1, 3'd3, 32'h73, 1'b0, 3'd0, 32'd0);
    chk("midrst_pend1", 32'(pend1), 32'd0);
    chk("midrst_pend2", 32'(pend2), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_we", 32'(write_enable), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
